// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper.
// FSM states, BCD limit, flash timing and status codes.
package score_keeper_pkg;

    typedef enum logic {
        TRACK = 1'b0,
        CLEAR = 1'b1
    } sk_state_t;

    localparam logic [15:0] BCD_MAX    = 16'h9999;
    localparam logic [2:0]  FLASH_HALF = 3'd5;
    localparam logic [4:0]  FLASH_LEN  = 5'd30;

    localparam logic [1:0] ST_PLAY_A = 2'b00;
    localparam logic [1:0] ST_MENU_A = 2'b01;
    localparam logic [1:0] ST_MENU_B = 2'b10;
    localparam logic [1:0] ST_PLAY_B = 2'b11;

endpackage

// File: rtl/score_keeper_bcd4_inc.sv
// Four-digit BCD incrementer by 0, 1 or 2.
// Saturates at 9999 instead of rolling over.
module bcd4_inc
    import score_keeper_pkg::*;
(
    input  logic [15:0] bcd_in,
    input  logic [1:0]  step,
    output logic [15:0] bcd_out
);

    logic [4:0]  sum;
    logic [4:0]  adj;
    logic [1:0]  carry;
    logic [15:0] raw;

    always_comb begin
        raw   = '0;
        sum   = '0;
        adj   = '0;
        carry = step;
        for (int i = 0; i < 4; i++) begin
            sum = {1'b0, bcd_in[4*i +: 4]} + {3'b000, carry};
            adj = sum - 5'd10;
            if (sum > 5'd9) begin
                raw[4*i +: 4] = adj[3:0];
                carry = 2'd1;
            end else begin
                raw[4*i +: 4] = sum[3:0];
                carry = 2'd0;
            end
        end
        bcd_out = (carry != 2'd0) ? BCD_MAX : raw;
    end

endmodule

// File: rtl/score_keeper.sv
// Score display tracker: BCD current/best score and record flag.
// Define SCORE_KEEPER_FLASH_EN to enable the record blink strobe.
module score_keeper
    import score_keeper_pkg::*;
(
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic [1:0]  status,
    input  logic [15:0] score,
    output logic [15:0] cur_bcd,
    output logic [15:0] best_bcd,
    output logic [15:0] best_score,
    output logic        new_record,
    output logic        flash,
    output logic        synced
);

    sk_state_t   state;
    sk_state_t   state_nxt;
    logic [15:0] shadow;
    logic [15:0] shadow_nxt;
    logic [15:0] cur_nxt;
    logic [15:0] inc_out;
    logic [1:0]  step;
    logic [1:0]  prev_status;
    logic        game_start;
    logic        rec_set;
    logic        nr_nxt;

    always_comb begin
        step = 2'd0;
        if (score > shadow) begin
            step = ((score - shadow) >= 16'd2) ? 2'd2 : 2'd1;
        end
    end

    bcd4_inc u_inc (
        .bcd_in  (cur_bcd),
        .step    (step),
        .bcd_out (inc_out)
    );

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        cur_nxt    = cur_bcd;
        unique case (state)
            TRACK: begin
                if (score < shadow) begin
                    state_nxt = CLEAR;
                end else if (step != 2'd0) begin
                    shadow_nxt = shadow + {14'd0, step};
                    cur_nxt    = inc_out;
                end
            end
            CLEAR: begin
                shadow_nxt = '0;
                cur_nxt    = '0;
                state_nxt  = TRACK;
            end
            default: state_nxt = TRACK;
        endcase
    end

    assign synced  = (shadow == score);
    assign rec_set = (state == TRACK) && (shadow > best_score);

    assign game_start =
        ((prev_status == ST_MENU_A) && (status == ST_PLAY_A)) ||
        ((prev_status == ST_MENU_B) && (status == ST_PLAY_B));

    // A record set on the same edge as a restart wins.
    assign nr_nxt = rec_set | (new_record & ~game_start);

    always_ff @(posedge clk_100ms) begin
        if (!rst) begin
            state       <= TRACK;
            shadow      <= '0;
            cur_bcd     <= '0;
            best_bcd    <= '0;
            best_score  <= '0;
            new_record  <= 1'b0;
            prev_status <= ST_MENU_A;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            cur_bcd     <= cur_nxt;
            new_record  <= nr_nxt;
            prev_status <= status;
            if (rec_set) begin
                best_score <= shadow;
                best_bcd   <= cur_bcd;
            end
        end
    end

`ifdef SCORE_KEEPER_FLASH_EN
    logic [2:0] half_cnt;
    logic [4:0] len_cnt;

    // len_cnt == 0 means the blink sequence is idle.
    always_ff @(posedge clk_100ms) begin
        if (!rst) begin
            flash    <= 1'b0;
            half_cnt <= '0;
            len_cnt  <= '0;
        end else if (nr_nxt && !new_record) begin
            flash    <= 1'b1;
            half_cnt <= 3'd1;
            len_cnt  <= 5'd1;
        end else if (len_cnt != 5'd0) begin
            if (len_cnt == FLASH_LEN) begin
                flash   <= 1'b0;
                len_cnt <= '0;
            end else begin
                len_cnt <= len_cnt + 5'd1;
                if (half_cnt == FLASH_HALF) begin
                    half_cnt <= 3'd1;
                    flash    <= ~flash;
                end else begin
                    half_cnt <= half_cnt + 3'd1;
                end
            end
        end
    end
`else
    assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper against a behavioural model.
// Driver pushes expected outputs; monitor pops and compares.
module tb_score_keeper;

    logic        clk_100ms;
    logic        rst;
    logic [1:0]  status;
    logic [15:0] score;
    logic [15:0] cur_bcd;
    logic [15:0] best_bcd;
    logic [15:0] best_score;
    logic        new_record;
    logic        flash;
    logic        synced;

    score_keeper dut (
        .clk_100ms  (clk_100ms),
        .rst        (rst),
        .status     (status),
        .score      (score),
        .cur_bcd    (cur_bcd),
        .best_bcd   (best_bcd),
        .best_score (best_score),
        .new_record (new_record),
        .flash      (flash),
        .synced     (synced)
    );

    initial clk_100ms = 1'b0;
    always #5 clk_100ms = ~clk_100ms;

    typedef struct {
        logic [15:0] cur;
        logic [15:0] bbcd;
        logic [15:0] best;
        logic        nr;
        logic        fl;
        logic        sy;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    // Reference state: plain integers, not the RTL encoding.
    int   m_shadow;
    int   m_best;
    bit   m_clr;
    bit   m_nr;
    int   m_ft;
    logic [1:0] m_prev;

    logic [1:0]  st_tb;
    logic [15:0] sc_tb;

    function automatic logic [15:0] to_bcd(input int v);
        int m;
        m = (v > 9999) ? 9999 : v;
        return {4'(m / 1000), 4'((m / 100) % 10),
                4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic tick(input logic r,
                        input logic [1:0] st,
                        input logic [15:0] sc);
        exp_t e;
        bit   gs;
        bit   rec;
        bit   nr_old;
        int   d;
        @(negedge clk_100ms);
        rst    = r;
        status = st;
        score  = sc;
        if (!r) begin
            m_shadow = 0;
            m_best   = 0;
            m_clr    = 0;
            m_nr     = 0;
            m_ft     = 30;
            m_prev   = 2'b01;
        end else begin
            nr_old = m_nr;
            gs  = (m_prev == 2'b01 && st == 2'b00) ||
                  (m_prev == 2'b10 && st == 2'b11);
            rec = !m_clr && (m_shadow > m_best);
            if (rec) begin
                m_best = m_shadow;
                m_nr   = 1;
            end else if (gs) begin
                m_nr = 0;
            end
            if (m_clr) begin
                m_shadow = 0;
                m_clr    = 0;
            end else if (int'(sc) > m_shadow) begin
                d = int'(sc) - m_shadow;
                m_shadow += (d > 2) ? 2 : d;
            end else if (int'(sc) < m_shadow) begin
                m_clr = 1;
            end
            m_prev = st;
            if (m_nr && !nr_old) m_ft = 0;
            else if (m_ft < 30) m_ft++;
        end
        e.cur  = to_bcd(m_shadow);
        e.bbcd = to_bcd(m_best);
        e.best = 16'(m_best);
        e.nr   = m_nr;
`ifdef SCORE_KEEPER_FLASH_EN
        e.fl   = (m_ft < 30) && ((m_ft / 5) % 2 == 0);
`else
        e.fl   = 1'b0;
`endif
        e.sy   = (m_shadow == int'(sc));
        q.push_back(e);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, st_tb, sc_tb);
    endtask

    task automatic go(input logic [1:0] st,
                      input logic [15:0] sc,
                      input int n);
        st_tb = st;
        sc_tb = sc;
        hold(n);
    endtask

    task automatic do_reset();
        st_tb = 2'b01;
        sc_tb = 16'd0;
        tick(1'b0, st_tb, sc_tb);
        tick(1'b0, st_tb, sc_tb);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_100ms);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cur_bcd", cur_bcd, e.cur);
                chk("best_bcd", best_bcd, e.bbcd);
                chk("best_score", best_score, e.best);
                chk("new_record", {15'd0, new_record}, {15'd0, e.nr});
                chk("flash", {15'd0, flash}, {15'd0, e.fl});
                chk("synced", {15'd0, synced}, {15'd0, e.sy});
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int r;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        status = 2'b01;
        score  = 16'd0;

        // Small steps, record and a restart of the game.
        do_reset();
        go(2'b01, 16'd0, 1);
        go(2'b00, 16'd0, 1);
        go(2'b00, 16'd1, 1);
        go(2'b00, 16'd3, 35);

        // Large jump converges two per tick.
        do_reset();
        go(2'b00, 16'd7, 6);
        go(2'b00, 16'd12, 8);
        go(2'b01, 16'd12, 2);
        go(2'b00, 16'd0, 3);
        for (int s = 1; s <= 13; s++) go(2'b00, 16'(s), 1);
        hold(35);

        // Reset during catch-up.
        do_reset();
        go(2'b00, 16'd4, 3);
        sc_tb = 16'd9;
        tick(1'b0, st_tb, sc_tb);
        hold(7);

        // Saturation of the BCD image.
        do_reset();
        go(2'b00, 16'd10005, 5010);

        // Randomized play.
        do_reset();
        st_tb = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                tick(1'b0, st_tb, sc_tb);
            end else if (st_tb == 2'b01 || st_tb == 2'b10) begin
                st_tb = (st_tb == 2'b01) ? 2'b00 : 2'b11;
                sc_tb = 16'd0;
                hold(1);
            end else if (r < 8) begin
                st_tb = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                hold(1);
            end else if (r < 12) begin
                sc_tb = sc_tb + 16'($urandom_range(3, 40));
                hold(1);
            end else begin
                sc_tb = sc_tb + 16'($urandom_range(0, 2));
                hold(1);
            end
        end

        repeat (3) @(posedge clk_100ms);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
